// File: rtl/int_arbiter_if.sv
// Interrupt arbiter bus: raw sources and pipeline status in, CP0/fetch controls out.
// The slave modport is the arbiter; the master modport is the pipeline/CP0 side.
interface int_arbiter_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NSRC  = 3
);
    logic [NSRC-1:0]  irq_in;
    logic             IE;
    logic [WIDTH-1:0] pc_next;
    logic             inst_ok;
    logic             eret;
    logic             stall;
    logic             redirect;
    logic [WIDTH-1:0] vector_pc;
    logic             IntRequest;
    logic [WIDTH-1:0] EPC_in;
    logic             IE_zero;
    logic             IE_one;
    logic [NSRC-1:0]  pending;
    logic [NSRC-1:0]  in_service;

    modport slave (
        input  irq_in, IE, pc_next, inst_ok, eret,
        output stall, redirect, vector_pc, IntRequest, EPC_in, IE_zero, IE_one,
               pending, in_service
    );

    modport master (
        output irq_in, IE, pc_next, inst_ok, eret,
        input  stall, redirect, vector_pc, IntRequest, EPC_in, IE_zero, IE_one,
               pending, in_service
    );
endinterface

// File: rtl/int_arbiter.sv
// Interrupt front end for CP0: synchronises and edge-detects sources, arbitrates by fixed
// priority with nesting, and sequences entry at a safe instruction boundary.
module int_arbiter #(
    parameter int unsigned     WIDTH      = 32,
    parameter int unsigned     NSRC       = 3,
    parameter logic [WIDTH-1:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [WIDTH-1:0] VEC_STRIDE = 32'h0000_0040
) (
    input logic           clk,
    input logic           clr,
    int_arbiter_if.slave  bus
);
    localparam int unsigned IdW = (NSRC > 1) ? $clog2(NSRC) : 1;

    typedef enum logic [2:0] {StIdle, StWait, StLatch, StEnter, StHold} state_e;

    state_e           state_q, state_d;
    logic [NSRC-1:0]  sync1_q, sync2_q, sync3_q;
    logic [NSRC-1:0]  pending_q, pending_d;
    logic [NSRC-1:0]  in_service_q, in_service_d;
    logic [IdW-1:0]   sel_q, sel_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [WIDTH-1:0] vec_q, vec_d;
    logic             ie_one_q;

    logic [IdW-1:0]   hp, hs;
    logic [NSRC-1:0]  edge_det, sel_oh, hs_oh;
    logic             eligible, stall, enter;

    assign edge_det = sync2_q & ~sync3_q;
    assign sel_oh   = NSRC'(1) << sel_q;
    assign hs_oh    = NSRC'(1) << hs;

    // Highest set index wins; later iterations overwrite earlier ones.
    always_comb begin
        hp = '0;
        hs = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (pending_q[i])    hp = IdW'(i);
            if (in_service_q[i]) hs = IdW'(i);
        end
    end

    assign eligible = bus.IE & (|pending_q) & ((in_service_q == '0) | (hp > hs));

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        epc_d   = epc_q;
        vec_d   = vec_q;
        stall   = 1'b0;
        enter   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (eligible) state_d = StWait;
            end
            StWait: begin
                if (!eligible) begin
                    state_d = StIdle;
                end else if (bus.inst_ok) begin
                    sel_d   = hp;
                    epc_d   = bus.pc_next;
                    state_d = StLatch;
                end
            end
            StLatch: begin
                // Vector registered here so it is valid throughout ENTER and held afterwards.
                stall   = 1'b1;
                vec_d   = VEC_BASE + WIDTH'(sel_q) * VEC_STRIDE;
                state_d = StEnter;
            end
            StEnter: begin
                stall   = 1'b1;
                enter   = 1'b1;
                state_d = StHold;
            end
            StHold: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // ERET clear is applied before the entry set so a coincident entry survives.
    always_comb begin
        in_service_d = in_service_q;
        if (bus.eret) in_service_d = in_service_d & ~hs_oh;
        if (enter)    in_service_d = in_service_d | sel_oh;
        pending_d = pending_q;
        if (enter)    pending_d = pending_d & ~sel_oh;
        pending_d = pending_d | edge_det;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= StIdle;
            sync1_q      <= '0;
            sync2_q      <= '0;
            sync3_q      <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            sel_q        <= '0;
            epc_q        <= '0;
            vec_q        <= '0;
            ie_one_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= bus.irq_in;
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            sel_q        <= sel_d;
            epc_q        <= epc_d;
            vec_q        <= vec_d;
            ie_one_q     <= bus.eret;
        end
    end

    assign bus.stall      = stall;
    assign bus.redirect   = enter;
    assign bus.IntRequest = enter;
    assign bus.IE_zero    = enter;
    assign bus.IE_one     = ie_one_q;
    assign bus.vector_pc  = vec_q;
    assign bus.EPC_in     = epc_q;
    assign bus.pending    = pending_q;
    assign bus.in_service = in_service_q;
endmodule

// File: tb/tb_int_arbiter.sv
// Directed bench for int_arbiter: stimulus pushes expected entries, a monitor checks each
// IntRequest pulse against the queue; pending/in_service/IE_one are checked inline.
module tb_int_arbiter;
    localparam int unsigned W = 32;
    localparam int unsigned N = 3;

    logic clk = 1'b0;
    logic clr;

    int_arbiter_if #(.WIDTH(W), .NSRC(N)) bus ();

    int_arbiter #(
        .WIDTH      (W),
        .NSRC       (N),
        .VEC_BASE   (32'h0000_0100),
        .VEC_STRIDE (32'h0000_0040)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] epc;
        logic [31:0] vec;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every entry pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.IntRequest === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_entry", 32'(bus.IntRequest), 32'd0);
            end else begin
                cur = sb.pop_front();
                check("entry_epc", bus.EPC_in, cur.epc);
                check("entry_vector", bus.vector_pc, cur.vec);
                check("entry_redirect", 32'(bus.redirect), 32'd1);
                check("entry_ie_zero", 32'(bus.IE_zero), 32'd1);
                check("entry_stall", 32'(bus.stall), 32'd1);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic raise(input logic [2:0] mask);
        bus.irq_in = '0;
        cyc(3);
        bus.irq_in = mask;
    endtask

    // Leaves time at #1 into the ENTER cycle.
    task automatic wait_entry();
        int k = 0;
        while (bus.IntRequest !== 1'b1 && k < 20) begin
            cyc(1);
            k++;
        end
        check("entry_seen", 32'(bus.IntRequest), 32'd1);
        check("entry_in_service_old", 32'(bus.in_service & 3'b000), 32'd0);
    endtask

    task automatic after_entry(input logic [2:0] isv, input logic [2:0] pnd);
        cyc(1);
        check("hold_intrequest", 32'(bus.IntRequest), 32'd0);
        check("hold_stall", 32'(bus.stall), 32'd0);
        check("hold_in_service", 32'(bus.in_service), 32'(isv));
        check("hold_pending", 32'(bus.pending), 32'(pnd));
    endtask

    task automatic do_eret(input logic [2:0] isv);
        bus.eret = 1'b1;
        cyc(1);
        bus.eret = 1'b0;
        check("eret_in_service", 32'(bus.in_service), 32'(isv));
        check("eret_ie_one", 32'(bus.IE_one), 32'd1);
        cyc(1);
        check("eret_ie_one_end", 32'(bus.IE_one), 32'd0);
    endtask

    initial begin
        bus.irq_in  = '0;
        bus.IE      = 1'b0;
        bus.pc_next = '0;
        bus.inst_ok = 1'b0;
        bus.eret    = 1'b0;
        clr         = 1'b1;
        cyc(2);
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_intrequest", 32'(bus.IntRequest), 32'd0);
        check("rst_pending", 32'(bus.pending), 32'd0);
        check("rst_in_service", 32'(bus.in_service), 32'd0);
        check("rst_vector", bus.vector_pc, 32'd0);
        check("rst_epc", bus.EPC_in, 32'd0);
        check("rst_ie_one", 32'(bus.IE_one), 32'd0);
        clr = 1'b0;
        cyc(2);

        // Single request, source 0, with 3-cycle conditioning latency.
        bus.IE      = 1'b1;
        bus.inst_ok = 1'b1;
        bus.pc_next = 32'h0000_2004;
        sb.push_back('{epc: 32'h0000_2004, vec: 32'h0000_0100});
        bus.irq_in = 3'b001;
        cyc(2);
        check("lat_pending_early", 32'(bus.pending), 32'd0);
        cyc(1);
        check("lat_pending_set", 32'(bus.pending), 32'b001);
        wait_entry();
        after_entry(3'b001, 3'b000);
        do_eret(3'b000);

        // Boundary wait: no capture while inst_ok is low.
        bus.inst_ok = 1'b0;
        bus.pc_next = 32'hDEAD_BEEF;
        raise(3'b010);
        cyc(4);
        for (int i = 0; i < 5; i++) begin
            check("bwait_stall", 32'(bus.stall), 32'd0);
            check("bwait_intrequest", 32'(bus.IntRequest), 32'd0);
            cyc(1);
        end
        sb.push_back('{epc: 32'h0000_3010, vec: 32'h0000_0140});
        bus.pc_next = 32'h0000_3010;
        bus.inst_ok = 1'b1;
        wait_entry();
        after_entry(3'b010, 3'b000);
        do_eret(3'b000);

        // Nesting: source 2 preempts source 0.
        bus.pc_next = 32'h0000_4000;
        sb.push_back('{epc: 32'h0000_4000, vec: 32'h0000_0100});
        raise(3'b001);
        wait_entry();
        after_entry(3'b001, 3'b000);
        bus.pc_next = 32'h0000_4100;
        sb.push_back('{epc: 32'h0000_4100, vec: 32'h0000_0180});
        raise(3'b100);
        wait_entry();
        after_entry(3'b101, 3'b000);
        do_eret(3'b001);
        // Same-level request while source 0 is in service must not enter.
        bus.pc_next = 32'h0000_5000;
        raise(3'b001);
        cyc(3);
        for (int i = 0; i < 15; i++) begin
            check("nest_block", 32'(bus.IntRequest), 32'd0);
            cyc(1);
        end
        check("nest_pending", 32'(bus.pending), 32'b001);
        sb.push_back('{epc: 32'h0000_5000, vec: 32'h0000_0100});
        do_eret(3'b000);
        wait_entry();
        after_entry(3'b001, 3'b000);
        do_eret(3'b000);

        // Simultaneous rise of sources 1 and 2.
        bus.pc_next = 32'h0000_6000;
        sb.push_back('{epc: 32'h0000_6000, vec: 32'h0000_0180});
        raise(3'b110);
        wait_entry();
        after_entry(3'b100, 3'b010);
        sb.push_back('{epc: 32'h0000_6000, vec: 32'h0000_0140});
        do_eret(3'b000);
        wait_entry();
        after_entry(3'b010, 3'b000);
        do_eret(3'b000);

        // IE gating holds a pending request until enabled.
        bus.IE      = 1'b0;
        bus.pc_next = 32'h0000_7000;
        raise(3'b100);
        cyc(3);
        check("gate_pending", 32'(bus.pending), 32'b100);
        for (int i = 0; i < 20; i++) begin
            check("gate_intrequest", 32'(bus.IntRequest), 32'd0);
            check("gate_stall", 32'(bus.stall), 32'd0);
            cyc(1);
        end
        sb.push_back('{epc: 32'h0000_7000, vec: 32'h0000_0180});
        bus.IE = 1'b1;
        wait_entry();
        after_entry(3'b100, 3'b000);
        do_eret(3'b000);

        // Asynchronous reset while in LATCH.
        raise(3'b001);
        begin
            int k = 0;
            while (bus.stall !== 1'b1 && k < 15) begin
                cyc(1);
                k++;
            end
        end
        check("latch_seen", 32'(bus.stall), 32'd1);
        check("latch_pending", 32'(bus.pending), 32'b001);
        clr        = 1'b1;
        bus.irq_in = '0;
        #1;
        check("clr_stall", 32'(bus.stall), 32'd0);
        check("clr_intrequest", 32'(bus.IntRequest), 32'd0);
        check("clr_pending", 32'(bus.pending), 32'd0);
        check("clr_epc", bus.EPC_in, 32'd0);
        cyc(2);
        clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("post_clr_intrequest", 32'(bus.IntRequest), 32'd0);
            cyc(1);
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
